// File: rtl/light_pkg.sv
// Shared phase codes, LED bit positions and decode/ordering helpers for the
// traffic-light monitor.
package light_pkg;

    localparam int LED_W = 7;

    localparam int LED_MAIN_R = 0;
    localparam int LED_MAIN_Y = 1;
    localparam int LED_MAIN_G = 2;
    localparam int LED_SIDE_R = 3;
    localparam int LED_SIDE_Y = 4;
    localparam int LED_SIDE_G = 5;
    localparam int LED_WALK   = 6;

    typedef enum logic [2:0] {
        PH_NONE    = 3'd0,
        PH_MAIN_G  = 3'd1,
        PH_MAIN_Y  = 3'd2,
        PH_WALK    = 3'd3,
        PH_SIDE_G  = 3'd4,
        PH_SIDE_Y  = 3'd5,
        PH_DARK    = 3'd6,
        PH_ILLEGAL = 3'd7
    } phase_t;

    localparam logic [LED_W-1:0] PAT_MAIN_G = (7'd1 << LED_MAIN_G) | (7'd1 << LED_SIDE_R);
    localparam logic [LED_W-1:0] PAT_MAIN_Y = (7'd1 << LED_MAIN_Y) | (7'd1 << LED_SIDE_R);
    localparam logic [LED_W-1:0] PAT_WALK   = (7'd1 << LED_MAIN_R) | (7'd1 << LED_SIDE_R)
                                            | (7'd1 << LED_WALK);
    localparam logic [LED_W-1:0] PAT_SIDE_G = (7'd1 << LED_MAIN_R) | (7'd1 << LED_SIDE_G);
    localparam logic [LED_W-1:0] PAT_SIDE_Y = (7'd1 << LED_MAIN_R) | (7'd1 << LED_SIDE_Y);

    function automatic phase_t light_decode(input logic [LED_W-1:0] leds);
        phase_t ph;
        case (leds)
            PAT_MAIN_G: ph = PH_MAIN_G;
            PAT_MAIN_Y: ph = PH_MAIN_Y;
            PAT_WALK:   ph = PH_WALK;
            PAT_SIDE_G: ph = PH_SIDE_G;
            PAT_SIDE_Y: ph = PH_SIDE_Y;
            7'd0:       ph = PH_DARK;
            default:    ph = PH_ILLEGAL;
        endcase
        return ph;
    endfunction

    function automatic bit is_legal_phase(input phase_t ph);
        return (ph >= PH_MAIN_G) && (ph <= PH_SIDE_Y);
    endfunction

    function automatic bit legal_next(input phase_t old_ph, input phase_t new_ph);
        bit ok;
        case (old_ph)
            PH_MAIN_G: ok = (new_ph == PH_MAIN_Y);
            PH_MAIN_Y: ok = (new_ph == PH_WALK) || (new_ph == PH_SIDE_G);
            PH_WALK:   ok = (new_ph == PH_SIDE_G);
            PH_SIDE_G: ok = (new_ph == PH_SIDE_Y);
            PH_SIDE_Y: ok = (new_ph == PH_MAIN_G);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating per-phase duration counter plus the completed-phase record
// register.
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             change,
    input  logic             emit,
    input  logic [2:0]       old_phase,
    output logic [CNT_W-1:0] cycles,
    output logic             done_valid,
    output logic [2:0]       done_phase,
    output logic [CNT_W-1:0] done_cycles
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    // Duration counter: a phase change starts the new phase at one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles <= '0;
        end else if (change) begin
            cycles <= ONE;
        end else begin
            cycles <= sat_inc(cycles);
        end
    end

    // Record register: captures the outgoing phase on the change edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_valid  <= 1'b0;
            done_phase  <= 3'd0;
            done_cycles <= '0;
        end else begin
            done_valid <= emit;
            if (emit) begin
                done_phase  <= old_phase;
                done_cycles <= cycles;
            end
        end
    end

endmodule

// File: rtl/light_monitor.sv
// Passive observer of the labkit light outputs: decodes, times and
// sanity-checks every light phase.
module light_monitor
    import light_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int CYC_W = 8
) (
    input  logic             clk,
    input  logic             g_reset,
    input  logic [LED_W-1:0] leds,
    input  logic             err_clear,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] phase_cycles,
    output logic             done_valid,
    output logic [2:0]       done_phase,
    output logic [CNT_W-1:0] done_cycles,
    output logic             conflict_err,
    output logic             seq_err,
    output logic [CYC_W-1:0] full_cycles
);

    logic [LED_W-1:0] leds_q;
    phase_t           phase_q;
    phase_t           phase_d;
    phase_t           prev_legal;
    logic             change;
    logic             emit;
    logic             seq_hit;
    logic             conflict_hit;
    logic             loop_hit;

    // Stage 1: register the raw light pattern
    always_ff @(posedge clk or posedge g_reset) begin
        if (g_reset) begin
            leds_q <= '0;
        end else begin
            leds_q <= leds;
        end
    end

    // Stage 2: decoded phase, ordering check and error flags
    assign phase_d      = light_decode(leds_q);
    assign change       = (phase_d != phase_q);
    assign emit         = change && (phase_q != PH_NONE);
    assign seq_hit      = change && is_legal_phase(prev_legal) && is_legal_phase(phase_d)
                          && !legal_next(prev_legal, phase_d);
    assign conflict_hit = change && (phase_d == PH_ILLEGAL);
    assign loop_hit     = change && (phase_q == PH_SIDE_Y) && (phase_d == PH_MAIN_G);

    // DARK and ILLEGAL break the chain so the next legal phase goes unchecked
    always_ff @(posedge clk or posedge g_reset) begin
        if (g_reset) begin
            phase_q    <= PH_NONE;
            prev_legal <= PH_NONE;
        end else if (change) begin
            phase_q    <= phase_d;
            prev_legal <= is_legal_phase(phase_d) ? phase_d : PH_NONE;
        end
    end

    // A fresh error on the same edge as err_clear keeps its flag set
    always_ff @(posedge clk or posedge g_reset) begin
        if (g_reset) begin
            conflict_err <= 1'b0;
            seq_err      <= 1'b0;
            full_cycles  <= '0;
        end else begin
            if (conflict_hit) begin
                conflict_err <= 1'b1;
            end else if (err_clear) begin
                conflict_err <= 1'b0;
            end
            if (seq_hit) begin
                seq_err <= 1'b1;
            end else if (err_clear) begin
                seq_err <= 1'b0;
            end
            if (loop_hit) begin
                full_cycles <= full_cycles + 1'b1;
            end
        end
    end

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (g_reset),
        .change     (change),
        .emit       (emit),
        .old_phase  (phase_q),
        .cycles     (phase_cycles),
        .done_valid (done_valid),
        .done_phase (done_phase),
        .done_cycles(done_cycles)
    );

    assign phase = phase_q;

endmodule

// File: tb/tb_light_monitor.sv
// Directed bench for light_monitor: full legal loop, ordering and conflict
// errors, counter saturation (narrow instance) and asynchronous reset.
module tb_light_monitor;

    localparam logic [6:0] L_DARK   = 7'b0000000;
    localparam logic [6:0] L_MAIN_G = 7'b0001100;
    localparam logic [6:0] L_MAIN_Y = 7'b0001010;
    localparam logic [6:0] L_WALK   = 7'b1001001;
    localparam logic [6:0] L_SIDE_G = 7'b0100001;
    localparam logic [6:0] L_SIDE_Y = 7'b0010001;
    localparam logic [6:0] L_BOTH_G = 7'b0100100;

    localparam logic [2:0] P_NONE = 3'd0, P_MG = 3'd1, P_MY = 3'd2, P_WALK = 3'd3,
                           P_SG = 3'd4, P_SY = 3'd5, P_DARK = 3'd6, P_ILL = 3'd7;

    typedef struct packed {
        logic [2:0]  ph;
        logic [15:0] cyc;
    } rec_t;

    logic        clk;
    logic        g_reset;
    logic [6:0]  leds;
    logic        err_clear;

    logic [2:0]  phase;
    logic [15:0] phase_cycles;
    logic        done_valid;
    logic [2:0]  done_phase;
    logic [15:0] done_cycles;
    logic        conflict_err;
    logic        seq_err;
    logic [7:0]  full_cycles;

    logic [2:0]  p4_phase;
    logic [3:0]  p4_phase_cycles;
    logic        p4_done_valid;
    logic [2:0]  p4_done_phase;
    logic [3:0]  p4_done_cycles;
    logic        p4_conflict_err;
    logic        p4_seq_err;
    logic [7:0]  p4_full_cycles;

    int   total;
    int   bad;
    rec_t rec_q[$];

    light_monitor dut (
        .clk         (clk),
        .g_reset     (g_reset),
        .leds        (leds),
        .err_clear   (err_clear),
        .phase       (phase),
        .phase_cycles(phase_cycles),
        .done_valid  (done_valid),
        .done_phase  (done_phase),
        .done_cycles (done_cycles),
        .conflict_err(conflict_err),
        .seq_err     (seq_err),
        .full_cycles (full_cycles)
    );

    light_monitor #(.CNT_W(4), .CYC_W(8)) dut4 (
        .clk         (clk),
        .g_reset     (g_reset),
        .leds        (leds),
        .err_clear   (err_clear),
        .phase       (p4_phase),
        .phase_cycles(p4_phase_cycles),
        .done_valid  (p4_done_valid),
        .done_phase  (p4_done_phase),
        .done_cycles (p4_done_cycles),
        .conflict_err(p4_conflict_err),
        .seq_err     (p4_seq_err),
        .full_cycles (p4_full_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record collector, sampled just after each active edge
    always @(posedge clk) begin
        #1;
        if (done_valid === 1'b1) rec_q.push_back(rec_t'({done_phase, done_cycles}));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_rec(input string tag, input logic [2:0] ph, input logic [15:0] cyc);
        rec_t r;
        r = '0;
        if (rec_q.size() != 0) r = rec_q.pop_front();
        chk({tag, "_phase"}, 32'(r.ph), 32'(ph));
        chk({tag, "_cycles"}, 32'(r.cyc), 32'(cyc));
    endtask

    // Called on a falling edge; the pattern is sampled by n rising edges
    task automatic hold(input logic [6:0] pat, input int n);
        leds = pat;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_phase"}, 32'(phase), 32'(P_NONE));
        chk({tag, "_phase_cycles"}, 32'(phase_cycles), 32'd0);
        chk({tag, "_done_valid"}, 32'(done_valid), 32'd0);
        chk({tag, "_done_phase"}, 32'(done_phase), 32'd0);
        chk({tag, "_done_cycles"}, 32'(done_cycles), 32'd0);
        chk({tag, "_conflict_err"}, 32'(conflict_err), 32'd0);
        chk({tag, "_seq_err"}, 32'(seq_err), 32'd0);
        chk({tag, "_full_cycles"}, 32'(full_cycles), 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        g_reset   = 1'b1;
        leds      = L_DARK;
        err_clear = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_state("rst");

        // leds_q already holds 0 out of reset, so DARK gains one edge before
        // the first sample: nine more edges make a 10-cycle DARK phase
        g_reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("dark_after_release", 32'(phase), 32'(P_DARK));
        repeat (7) @(negedge clk);

        hold(L_MAIN_G, 20);
        hold(L_MAIN_Y, 5);
        hold(L_WALK, 8);
        hold(L_SIDE_G, 15);
        hold(L_SIDE_Y, 5);
        hold(L_MAIN_G, 20);
        chk("loop_phase", 32'(phase), 32'(P_MG));
        chk("loop_full_cycles", 32'(full_cycles), 32'd1);
        chk("loop_seq_err", 32'(seq_err), 32'd0);
        chk("loop_conflict_err", 32'(conflict_err), 32'd0);

        // MAIN_G -> SIDE_G skips MAIN_Y
        leds = L_SIDE_G;
        repeat (2) @(negedge clk);
        chk("skip_phase", 32'(phase), 32'(P_SG));
        chk("skip_seq_err", 32'(seq_err), 32'd1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("clear_seq_err", 32'(seq_err), 32'd0);

        // SIDE_G -> MAIN_G is illegal and lands on the same edge as the clear
        leds = L_MAIN_G;
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("clear_vs_new_seq_err", 32'(seq_err), 32'd1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("reclear_seq_err", 32'(seq_err), 32'd0);
        @(negedge clk);

        // Both greens for three cycles, then SIDE_G without an ordering error
        leds = L_BOTH_G;
        repeat (2) @(negedge clk);
        chk("illegal_phase", 32'(phase), 32'(P_ILL));
        chk("illegal_conflict_err", 32'(conflict_err), 32'd1);
        @(negedge clk);
        leds = L_SIDE_G;
        repeat (2) @(negedge clk);
        chk("after_illegal_phase", 32'(phase), 32'(P_SG));
        chk("after_illegal_seq_err", 32'(seq_err), 32'd0);
        chk("conflict_sticky", 32'(conflict_err), 32'd1);
        chk("full_cycles_kept", 32'(full_cycles), 32'd1);
        repeat (2) @(negedge clk);

        expect_rec("rec_dark", P_DARK, 16'd10);
        expect_rec("rec_main_g", P_MG, 16'd20);
        expect_rec("rec_main_y", P_MY, 16'd5);
        expect_rec("rec_walk", P_WALK, 16'd8);
        expect_rec("rec_side_g", P_SG, 16'd15);
        expect_rec("rec_side_y", P_SY, 16'd5);
        expect_rec("rec_main_g2", P_MG, 16'd20);
        expect_rec("rec_side_g2", P_SG, 16'd3);
        expect_rec("rec_main_g3", P_MG, 16'd4);
        expect_rec("rec_illegal", P_ILL, 16'd3);
        chk("rec_count", 32'(rec_q.size()), 32'd0);

        // Asynchronous reset in the middle of a SIDE_G phase
        #2;
        g_reset = 1'b1;
        #1;
        chk_reset_state("async_rst");
        @(negedge clk);
        leds = L_DARK;
        @(negedge clk);
        g_reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("no_aborted_record", 32'(rec_q.size()), 32'd0);
        chk("post_rst_phase", 32'(phase), 32'(P_DARK));

        // Long MAIN_G: the 4-bit instance saturates, the 16-bit one does not
        hold(L_MAIN_G, 40);
        chk("sat_phase_cycles", 32'(p4_phase_cycles), 32'd15);
        chk("wide_phase_cycles", 32'(phase_cycles), 32'd39);
        leds = L_MAIN_Y;
        @(negedge clk);
        chk("wide_phase_cycles_end", 32'(phase_cycles), 32'd40);
        leds = L_WALK;
        @(negedge clk);
        chk("long_done_valid", 32'(done_valid), 32'd1);
        chk("long_done_phase", 32'(done_phase), 32'(P_MG));
        chk("long_done_cycles", 32'(done_cycles), 32'd40);
        chk("sat_done_cycles", 32'(p4_done_cycles), 32'd15);
        @(negedge clk);
        chk("b2b_done_valid", 32'(done_valid), 32'd1);
        chk("b2b_done_phase", 32'(done_phase), 32'(P_MY));
        chk("b2b_done_cycles", 32'(done_cycles), 32'd1);
        @(negedge clk);
        chk("b2b_done_valid_drop", 32'(done_valid), 32'd0);
        chk("b2b_seq_err", 32'(seq_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/light_monitor.md
Name: light_monitor

Overview:
- Passive observer on the 7-bit `leds` output of the traffic-light controller (`labkit`).
- Registers and decodes the light pattern into a phase code and times each phase in clock cycles.
- Emits one record per completed phase and flags two kinds of error: conflicting light patterns and out-of-order phase sequences.
- Sits beside `labkit` in the top level and in benches; it acts as the receiving end of the `leds` interface.

Parameters:
- CNT_W, 16, width of the phase-duration counters (saturating).
- CYC_W, 8, width of the completed-full-cycle counter (wrapping).

Ports:
- clk  input  1  system clock.
- g_reset  input  1  reset, asynchronous, active-high.
- leds  input  7  light pattern from `labkit`: [0]=main_red, [1]=main_yellow, [2]=main_green, [3]=side_red, [4]=side_yellow, [5]=side_green, [6]=walk.
- err_clear  input  1  synchronous clear of the sticky error flags.
- phase  output  3  current decoded phase.
- phase_cycles  output  CNT_W  cycles spent so far in the current phase.
- done_valid  output  1  one-cycle pulse: a phase just ended.
- done_phase  output  3  the phase that ended (valid with done_valid).
- done_cycles  output  CNT_W  duration of the ended phase (valid with done_valid).
- conflict_err  output  1  sticky: an illegal pattern was seen.
- seq_err  output  1  sticky: an illegal phase order was seen.
- full_cycles  output  CYC_W  count of SIDE_Y->MAIN_G transitions.

Behaviour:
- Phase codes:
  - NONE=0
  - MAIN_G=1: main G, side R, walk 0
  - MAIN_Y=2: main Y, side R, walk 0
  - WALK=3: main R, side R, walk 1
  - SIDE_G=4: main R, side G, walk 0
  - SIDE_Y=5: main R, side Y, walk 0
  - DARK=6: all 7 bits 0
  - ILLEGAL=7: any other pattern
- Stage 1: `leds` is registered into `leds_q`. Reset value of `leds_q` is 0.
- Stage 2: the decode of `leds_q` is registered into `phase`. Latency from `leds` to `phase` is 2 clocks.
- Reset values: phase=NONE; phase_cycles=0; done_valid=0; done_phase=0; done_cycles=0; conflict_err=0; seq_err=0; full_cycles=0; prev_legal=NONE.
  - Reset takes effect immediately mid-operation and discards any partial phase.
- Phase change (decoded value differs from `phase`, edge E):
  - `phase` takes the new value and `phase_cycles` loads 1.
  - If the old phase was not NONE: done_valid=1 for the cycle after E, done_phase=old phase, done_cycles=old phase_cycles. Leaving NONE emits no record.
- No change: `phase_cycles` increments and saturates at all-ones. `done_valid` is 0.
  - A pattern held N clocks gives done_cycles=N.
- Legal order:
  - MAIN_G->MAIN_Y
  - MAIN_Y->WALK or SIDE_G
  - WALK->SIDE_G
  - SIDE_G->SIDE_Y
  - SIDE_Y->MAIN_G
- Sequence check applies only when both the old and new phases are in 1..5. Any other 1..5 -> 1..5 change sets `seq_err`.
- Entering DARK or ILLEGAL clears `prev_legal`, so the next legal phase is not checked.
- Entering ILLEGAL sets `conflict_err`. ILLEGAL and DARK are timed and reported like any other phase.
- SIDE_Y->MAIN_G increments `full_cycles`, wrapping at 2^CYC_W.
- err_clear:
  - Clears both sticky flags at the next edge.
  - If a new error is detected on the same edge, the error wins and the flag stays 1.
- Two consecutive distinct patterns each produce a record. A 1-cycle phase gives done_cycles=1, and done_valid is then high on back-to-back cycles.

Decomposition:
- Shared package `light_pkg`:
  - Phase codes.
  - LED bit-index constants.
  - Function `light_decode(leds) -> phase`.
  - Function `legal_next(old, new) -> bit`.
- Sub-module `phase_timer`: saturating CNT_W counter with load-1/increment, plus the output record register.
- Decode, sequence check and error flags remain in `light_monitor`.

Test Plan:
- Reset then hold leds=0 for 10 clk, then MAIN_G (7'b0001100) for 20 clk:
  - phase=DARK 2 clk after reset release.
  - At the change: done_valid with done_phase=6, done_cycles=10.
  - phase=MAIN_G.
- Full legal loop MAIN_G 20, MAIN_Y 5, WALK 8, SIDE_G 15, SIDE_Y 5, MAIN_G:
  - Five records with exact durations 20/5/8/15/5.
  - full_cycles=1; seq_err=0; conflict_err=0.
- MAIN_G then SIDE_G directly:
  - seq_err=1 at the record edge.
  - Pulse err_clear -> 0 next edge.
  - Clear coincident with a new illegal order -> seq_err stays 1.
- leds=7'b0100100 (both greens) for 3 clk:
  - phase=ILLEGAL; conflict_err=1.
  - Record ILLEGAL/3.
  - Following SIDE_G raises no seq_err.
- CNT_W=4, hold MAIN_G 40 clk: phase_cycles sticks at 15 and done_cycles=15.
- Assert g_reset mid-SIDE_G:
  - All outputs return to reset values immediately.
  - No done_valid for the aborted phase.
